alu_div8: RTL and testbench

ALU_DIV8 -- requirements
Module: alu_div8

---
 rtl/alu_div8.sv | 135 +++++++++++++
 tb/tb_alu_div8.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_div8.sv
// alu_div8: iterative unsigned restoring divider.
// Produces one quotient bit per clock using a WIDTH+1-bit trial subtraction.
// A zero divisor skips the iterations and reports div_by_zero in the very next cycle.
module alu_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CW-1:0]    r_cnt;       // quotient bits still to produce
    logic [WIDTH-1:0] r_dvd;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvs;       // latched divisor
    logic [WIDTH-1:0] r_rem;       // partial remainder (always < divisor)
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // A new request is only taken while no division is in flight.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(1));

    // Trial subtraction.
    // The shifted partial remainder is below 2*divisor, so bit WIDTH of the
    // difference is set exactly when the subtraction borrows.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_sub      = w_shift - {1'b0, r_dvs};
    assign w_q_bit    = ~w_sub[WIDTH];
    assign w_rem_next = w_q_bit ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_q_bit};

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Datapath: operand latch, iteration, and result registers.
    // NOTE: every register here is reset because results are visible outputs that must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (divisor == '0) begin
                r_cnt  <= '0;
                r_quot <= '1;
                r_remo <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH);
            end
        end else if (r_state == S_RUN) begin
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_quot <= w_dvd_next;
                r_remo <= w_rem_next;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div8.sv
// tb_alu_div8: directed bench for alu_div8 (WIDTH=8).
// Expected results are hand-computed constants, except in the short sweep,
// where the reference comes from integer division done in the bench.
module tb_alu_div8;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_div8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: drives one start cycle, returns at the first negedge after acceptance.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Counts cycles after acceptance until done (bounded).
    // Also counts busy cycles and any change of the result outputs while waiting.
    task automatic wait_done(output int cyc, output int nbusy, output int nchg);
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        logic         z0;
        q0    = quotient;
        r0    = remainder;
        z0    = div_by_zero;
        cyc   = 1;
        nbusy = 0;
        nchg  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) nchg++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int cyc;
        int nb;
        int nc;
        launch(a, b);
        wait_done(cyc, nb, nc);
        check({tag, " latency"},   cyc, ez ? 1 : 9);
        check({tag, " busy_cyc"},  nb,  ez ? 0 : 8);
        check({tag, " held_run"},  nc,  0);
        check({tag, " quotient"},  quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dbz"},       div_by_zero, ez);
        check({tag, " busy_done"}, busy, 0);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
        check({tag, " q_held"},     quotient, eq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           cyc;
        int           nb;
        int           nc;
        int           ndone;
        int           dcyc;
        logic [W-1:0] got_q;
        logic [W-1:0] got_r;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_div("100/7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        run_div("5/0",     8'd5,   8'd0,   8'hFF,  8'd5,   1'b1);
        run_div("3/10",    8'd3,   8'd10,  8'd0,   8'd3,   1'b0);
        run_div("255/1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        run_div("255/255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
        run_div("0/5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0);
        run_div("128/16",  8'd128, 8'd16,  8'd8,   8'd0,   1'b0);
        run_div("254/127", 8'd254, 8'd127, 8'd2,   8'd0,   1'b0);

        // Starts while busy are ignored
        launch(8'd200, 8'd9);
        ndone = 0;
        dcyc  = 0;
        got_q = '0;
        got_r = '0;
        for (int c = 1; c <= 20; c++) begin
            if (done === 1'b1) begin
                ndone++;
                got_q = quotient;
                got_r = remainder;
                dcyc  = c;
            end
            start    = (c == 2 || c == 5);
            dividend = 8'd10;
            divisor  = 8'd3;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore done_count", ndone, 1);
        check("ignore latency", dcyc, 9);
        check("ignore quotient", got_q, 22);
        check("ignore remainder", got_r, 2);

        // Reset in the middle of a run
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        check("midrun busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort dbz", div_by_zero, 0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort no_done", ndone, 0);
        rst_n = 1'b1;
        run_div("50/6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

        // Back-to-back start in the DONE cycle
        launch(8'd100, 8'd7);
        wait_done(cyc, nb, nc);
        check("b2b first latency", cyc, 9);
        check("b2b first quotient", quotient, 14);
        check("b2b first remainder", remainder, 2);
        launch(8'd255, 8'd255);
        check("b2b second busy", busy, 1);
        wait_done(cyc, nb, nc);
        check("b2b second latency", cyc, 9);
        check("b2b second quotient", quotient, 1);
        check("b2b second remainder", remainder, 0);
        launch(8'd7, 8'd0);
        check("b2b zero done", done, 1);
        check("b2b zero quotient", quotient, 255);
        check("b2b zero remainder", remainder, 7);
        check("b2b zero dbz", div_by_zero, 1);
        @(negedge clk);
        check("b2b zero done_pulse", done, 0);

        // Short sweep with a reference computed in the bench
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (i % 10 == 0) b = '0;
            if (b == '0) begin
                run_div("sweep", a, b, 8'hFF, a, 1'b1);
            end else begin
                run_div("sweep", a, b, W'(int'(a) / int'(b)), W'(int'(a) % int'(b)), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
